stim_pattern_gen: RTL and testbench

- Parametrised stimulus sequencer for lab benches and on-board self-test of combinational DUTs.
- Generalises a fixed 3-bit, fixed-period input sweep to W-bit patterns with a configurable dwell time and selectable sequence modes.
- Adds start/stop control, optional looping, a per-pattern strobe and a completion flag.
- Its output drives DUT inputs directly; a checker samples DUT outputs on the strobe.

---
 rtl/stim_pattern_gen_pkg.sv | 17 +
 rtl/stim_dwell_timer.sv | 32 +++
 rtl/stim_pattern_gen.sv | 118 +++++++++++
 tb/tb_stim_pattern_gen.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/stim_pattern_gen_pkg.sv
// Shared constants for the stimulus pattern generator: sequence modes and FSM state encoding.
// Mode 3 (Gray) only yields Gray code when STIM_PATTERN_GEN_GRAY_EN is defined.

package stim_pattern_gen_pkg;

  localparam logic [1:0] MODE_UP   = 2'd0;
  localparam logic [1:0] MODE_DOWN = 2'd1;
  localparam logic [1:0] MODE_WALK = 2'd2;
  localparam logic [1:0] MODE_GRAY = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/stim_dwell_timer.sv
// Dwell timer: counts 0..DWELL-1 while enabled and flags the last cycle of each dwell period.
// The clear input has priority over the enable input and returns the count to zero.

module stim_dwell_timer #(
  parameter  int DWELL = 100,
  localparam int CNT_W = $clog2(DWELL) + 1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic en,
  output logic expire
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(DWELL - 1);

  logic [CNT_W-1:0] cnt;

  assign expire = en && (cnt == LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else if (en) begin
      if (cnt == LAST) cnt <= '0;
      else             cnt <= cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/stim_pattern_gen.sv
// Stimulus sequencer: steps a W-bit pattern through up/down/walking-one/Gray sequences, DWELL cycles per value.
// Define STIM_PATTERN_GEN_GRAY_EN to build Gray mode; without it, mode 3 runs the binary-up sequence.
//
// state   | meaning
// ST_IDLE | waiting for start; pattern holds its last value
// ST_RUN  | sequencing; strobe marks each new pattern
// ST_DONE | non-looping run finished; done held high

module stim_pattern_gen
  import stim_pattern_gen_pkg::*;
#(
  parameter int W     = 3,
  parameter int DWELL = 100
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic         stop,
  input  logic         loop_en,
  input  logic [1:0]   mode,
  output logic [W-1:0] pattern,
  output logic         strobe,
  output logic         busy,
  output logic         done
);

  state_t         state;
  logic [W-1:0]   idx;
  logic [1:0]     mode_q;
  logic           loop_q;
  logic           expire;
  logic           tmr_clear;
  logic           tmr_en;

  function automatic logic [W-1:0] map_pattern(input logic [1:0] m, input logic [W-1:0] i);
    logic [W-1:0] one;
    one = W'(1);
    case (m)
      MODE_DOWN: map_pattern = ~i;
      MODE_WALK: map_pattern = one << i;
`ifdef STIM_PATTERN_GEN_GRAY_EN
      MODE_GRAY: map_pattern = i ^ (i >> 1);
`endif
      default:   map_pattern = i;
    endcase
  endfunction

  // Walking-one sequence is W long; all other modes cover the full 2^W range.
  function automatic logic [W-1:0] last_idx(input logic [1:0] m);
    if (m == MODE_WALK) last_idx = W'(W - 1);
    else                last_idx = '1;
  endfunction

  assign tmr_en    = (state == ST_RUN);
  assign tmr_clear = (state != ST_RUN) || stop;

  stim_dwell_timer #(.DWELL(DWELL)) u_dwell (
    .clk    (clk),
    .rst_n  (rst_n),
    .clear  (tmr_clear),
    .en     (tmr_en),
    .expire (expire)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= ST_IDLE;
      idx     <= '0;
      pattern <= '0;
      strobe  <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
      mode_q  <= MODE_UP;
      loop_q  <= 1'b0;
    end else begin
      strobe <= 1'b0;
      case (state)
        ST_IDLE, ST_DONE: begin
          if (start && !stop) begin
            state   <= ST_RUN;
            mode_q  <= mode;
            loop_q  <= loop_en;
            idx     <= '0;
            pattern <= map_pattern(mode, '0);
            strobe  <= 1'b1;
            busy    <= 1'b1;
            done    <= 1'b0;
          end
        end
        ST_RUN: begin
          if (stop) begin
            state <= ST_IDLE;
            busy  <= 1'b0;
            done  <= 1'b0;
          end else if (expire) begin
            if (idx == last_idx(mode_q)) begin
              if (loop_q) begin
                idx     <= '0;
                pattern <= map_pattern(mode_q, '0);
                strobe  <= 1'b1;
              end else begin
                state <= ST_DONE;
                busy  <= 1'b0;
                done  <= 1'b1;
              end
            end else begin
              idx     <= idx + W'(1);
              pattern <= map_pattern(mode_q, idx + W'(1));
              strobe  <= 1'b1;
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_stim_pattern_gen.sv
// Scoreboard bench for stim_pattern_gen (W=3, DWELL=4): expected patterns queued per run, popped on each strobe.
// Mode-3 expectations follow STIM_PATTERN_GEN_GRAY_EN the same way the design does.

module tb_stim_pattern_gen;

  localparam int W     = 3;
  localparam int DWELL = 4;

  logic         clk;
  logic         rst_n;
  logic         start;
  logic         stop;
  logic         loop_en;
  logic [1:0]   mode;
  logic [W-1:0] pattern;
  logic         strobe;
  logic         busy;
  logic         done;

  int checks;
  int errors;
  logic [W-1:0] exp_q[$];

  stim_pattern_gen #(.W(W), .DWELL(DWELL)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start),
    .stop    (stop),
    .loop_en (loop_en),
    .mode    (mode),
    .pattern (pattern),
    .strobe  (strobe),
    .busy    (busy),
    .done    (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Monitor: every strobe must match the next queued pattern.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && strobe === 1'b1) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_strobe: pattern=%0d, no pattern expected", pattern);
      end else begin
        logic [W-1:0] e;
        e = exp_q.pop_front();
        if (pattern !== e) begin
          errors++;
          $display("FAIL strobe_pattern: got %0d, expected %0d", pattern, e);
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push_list(input int n, input logic [W-1:0] v [8]);
    for (int i = 0; i < n; i++) exp_q.push_back(v[i]);
  endtask

  task automatic pulse_start(input logic [1:0] m, input logic le);
    mode    = m;
    loop_en = le;
    start   = 1'b1;
    tick(1);
    start   = 1'b0;
  endtask

  // Runs a non-looping sequence of n patterns and checks the done timing (n*DWELL after first strobe).
  task automatic full_run(input string tag, input logic [1:0] m, input int n,
                          input logic [W-1:0] v [8]);
    push_list(n, v);
    pulse_start(m, 1'b0);
    chk({tag, "_busy_first"}, busy, 1);
    chk({tag, "_done_first"}, done, 0);
    tick(n * DWELL - 1);
    chk({tag, "_busy_before_end"}, busy, 1);
    chk({tag, "_done_before_end"}, done, 0);
    tick(1);
    chk({tag, "_done_end"}, done, 1);
    chk({tag, "_busy_end"}, busy, 0);
    chk({tag, "_pattern_hold"}, pattern, v[n-1]);
    tick(3);
    chk({tag, "_done_sticky"}, done, 1);
    chk({tag, "_pattern_still"}, pattern, v[n-1]);
    chk({tag, "_queue_drained"}, exp_q.size(), 0);
  endtask

  logic [W-1:0] seq_up   [8] = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd7};
  logic [W-1:0] seq_down [8] = '{3'd7, 3'd6, 3'd5, 3'd4, 3'd3, 3'd2, 3'd1, 3'd0};
  logic [W-1:0] seq_walk [8] = '{3'b001, 3'b010, 3'b100, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0};
`ifdef STIM_PATTERN_GEN_GRAY_EN
  logic [W-1:0] seq_m3   [8] = '{3'b000, 3'b001, 3'b011, 3'b010, 3'b110, 3'b111, 3'b101, 3'b100};
`else
  logic [W-1:0] seq_m3   [8] = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd7};
`endif
  logic [W-1:0] seq_loop [8] = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd7};

  initial begin
    checks  = 0;
    errors  = 0;
    rst_n   = 1'b0;
    start   = 1'b0;
    stop    = 1'b0;
    loop_en = 1'b0;
    mode    = 2'd0;
    #2;
    chk("reset_pattern", pattern, 0);
    chk("reset_strobe", strobe, 0);
    chk("reset_busy", busy, 0);
    chk("reset_done", done, 0);
    tick(2);
    rst_n = 1'b1;
    tick(2);

    full_run("up",   2'd0, 8, seq_up);
    full_run("down", 2'd1, 8, seq_down);
    full_run("walk", 2'd2, 3, seq_walk);
    full_run("m3",   2'd3, 8, seq_m3);

    // stop while DONE has no effect
    stop = 1'b1;
    tick(2);
    stop = 1'b0;
    chk("stop_in_done_done", done, 1);
    chk("stop_in_done_busy", busy, 0);

    // Looping run; mode/loop_en changes mid-run must be ignored.
    push_list(8, seq_loop);
    exp_q.push_back(3'd0);
    exp_q.push_back(3'd1);
    pulse_start(2'd0, 1'b1);
    mode    = 2'd1;
    loop_en = 1'b0;
    tick(39);
    chk("loop_busy", busy, 1);
    chk("loop_done", done, 0);
    chk("loop_pattern", pattern, 1);
    stop = 1'b1;
    tick(1);
    stop = 1'b0;
    chk("loop_stop_busy", busy, 0);
    chk("loop_stop_done", done, 0);
    chk("loop_stop_pattern", pattern, 1);
    chk("loop_queue_drained", exp_q.size(), 0);

    // Stop during pattern 5, then restart.
    push_list(6, seq_up);
    pulse_start(2'd0, 1'b0);
    tick(21);
    stop = 1'b1;
    tick(1);
    stop = 1'b0;
    chk("stop5_busy", busy, 0);
    chk("stop5_pattern", pattern, 5);
    chk("stop5_strobe", strobe, 0);
    exp_q.push_back(3'd0);
    start = 1'b1;
    tick(1);
    chk("restart_busy", busy, 1);
    chk("restart_pattern", pattern, 0);
    chk("restart_strobe", strobe, 1);
    tick(2);
    start = 1'b0;
    chk("start_in_run_pattern", pattern, 0);
    chk("start_in_run_busy", busy, 1);
    stop = 1'b1;
    tick(1);
    stop = 1'b0;
    chk("restart_queue_drained", exp_q.size(), 0);

    // start and stop together in IDLE: stop wins.
    start = 1'b1;
    stop  = 1'b1;
    tick(2);
    start = 1'b0;
    stop  = 1'b0;
    tick(1);
    chk("start_stop_busy", busy, 0);
    chk("start_stop_done", done, 0);

    // Asynchronous reset mid-run.
    exp_q.push_back(3'd7);
    exp_q.push_back(3'd6);
    pulse_start(2'd1, 1'b0);
    tick(5);
    rst_n = 1'b0;
    #1;
    chk("rst_mid_pattern", pattern, 0);
    chk("rst_mid_busy", busy, 0);
    chk("rst_mid_done", done, 0);
    chk("rst_mid_strobe", strobe, 0);
    tick(2);
    rst_n = 1'b1;
    tick(3);
    chk("rst_after_busy", busy, 0);
    chk("rst_queue_drained", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
